// File: rtl/norm_sched_pkg.sv
// norm_sched_pkg
// Shared types for the normalizer request scheduler: the RayDirection payload,
// the scheduler state encoding and a helper sizing the requester-index width.
// RayDirection component width comes from the global `WIDTH macro (default 16).

`ifndef WIDTH
`define WIDTH 16
`endif

package norm_sched_pkg;

  localparam int WIDTH = `WIDTH;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
  } RayDirection;

  typedef enum logic [0:0] {
    SCHED_RUN   = 1'b0,
    SCHED_DRAIN = 1'b1
  } sched_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int req_id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/norm_id_fifo.sv
// norm_id_fifo
// Synchronous FIFO holding the requester index of every ray in flight, so
// in-order normalizer results can be routed back to their owners.
// dout shows the head entry combinationally whenever empty is low.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   push, din   enqueue din (ignored when full)
//   pop         dequeue head (ignored when empty)
//   dout        head entry
//   empty, full occupancy flags

module norm_id_fifo #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_CNT);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_q];

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/norm_request_scheduler.sv
// norm_request_scheduler
// Shares one pipelined normalization unit between NUM_REQ ray requesters.
// A round-robin arbiter grants one request per cycle, a credit counter caps
// rays in flight, and an ID FIFO routes in-order results back to owners.
// Optional statistics counters are built when NORM_SCHED_STATS_EN is defined.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req_valid/req_dir per-requester request and direction
//   req_ready         one-hot grant (combinational)
//   flush/flush_done  stop granting and drain; pulse when drained
//   norm_start/dir    registered issue to the normalizer
//   norm_valid/normal normalizer result (cannot be stalled)
//   resp_valid/normal registered one-hot result and broadcast data
//   inflight          current credit usage
//   err_underflow     sticky: result arrived with nothing outstanding
//   stat_issued/stall statistics (0 unless NORM_SCHED_STATS_EN)

module norm_request_scheduler
  import norm_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_INFLIGHT = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  RayDirection [NUM_REQ-1:0]         req_dir,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic                              flush,
  output logic                              flush_done,
  output logic                              norm_start,
  output RayDirection                       norm_dir,
  input  logic                              norm_valid,
  input  RayDirection                       norm_normal,
  output logic [NUM_REQ-1:0]                resp_valid,
  output RayDirection                       resp_normal,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              err_underflow,
  output logic [31:0]                       stat_issued,
  output logic [31:0]                       stat_stall
);

  localparam int ID_W  = req_id_w(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

  sched_state_t      state_q;
  sched_state_t      state_d;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_found;
  logic              can_issue;
  logic              issue;
  logic              retire;
  logic              underflow;
  logic [CNT_W-1:0]  inflight_q;
  logic [ID_W-1:0]   fifo_dout;
  logic              fifo_empty;
  logic              fifo_full;
  logic              norm_start_q;
  RayDirection       norm_dir_q;
  logic [NUM_REQ-1:0] resp_valid_q;
  RayDirection       resp_normal_q;
  logic              err_q;

  // Credit uses only the registered count, so a retire cannot free a slot
  // for a grant in the same cycle. The FIFO-full term is a redundant guard.
  assign can_issue = (state_q == SCHED_RUN) && (inflight_q < MAX_CNT) && !fifo_full;
  assign issue     = can_issue && grant_found;
  assign retire    = norm_valid && !fifo_empty;
  assign underflow = norm_valid && fifo_empty;

  // Search for the first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!grant_found && req_valid[ID_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (issue) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Flush while draining is ignored; leaving DRAIN emits flush_done.
  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      SCHED_RUN: begin
        if (flush) begin
          state_d = SCHED_DRAIN;
        end
      end
      SCHED_DRAIN: begin
        if (inflight_q == '0) begin
          state_d    = SCHED_RUN;
          flush_done = 1'b1;
        end
      end
      default: state_d = SCHED_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SCHED_RUN;
      rr_ptr_q      <= '0;
      inflight_q    <= '0;
      norm_start_q  <= 1'b0;
      norm_dir_q    <= '0;
      resp_valid_q  <= '0;
      resp_normal_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      norm_start_q <= issue;
      resp_valid_q <= '0;
      if (issue) begin
        rr_ptr_q   <= (grant_idx == LAST_ID) ? '0 : grant_idx + ID_W'(1);
        norm_dir_q <= req_dir[grant_idx];
      end
      if (retire) begin
        resp_valid_q[fifo_dout] <= 1'b1;
        resp_normal_q           <= norm_normal;
      end
      if (underflow) begin
        err_q <= 1'b1;
      end
      if (issue && !retire) begin
        inflight_q <= inflight_q + CNT_W'(1);
      end else if (retire && !issue) begin
        inflight_q <= inflight_q - CNT_W'(1);
      end
    end
  end

  norm_id_fifo #(
    .DEPTH  (MAX_INFLIGHT),
    .DATA_W (ID_W)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (issue),
    .pop   (retire),
    .din   (grant_idx),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign norm_start    = norm_start_q;
  assign norm_dir      = norm_dir_q;
  assign resp_valid    = resp_valid_q;
  assign resp_normal   = resp_normal_q;
  assign inflight      = inflight_q;
  assign err_underflow = err_q;

`ifdef NORM_SCHED_STATS_EN
  logic [31:0] stat_issued_q;
  logic [31:0] stat_stall_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (issue && (stat_issued_q != '1)) begin
        stat_issued_q <= stat_issued_q + 32'd1;
      end
      if ((|req_valid) && (state_q == SCHED_RUN) && (inflight_q == MAX_CNT) &&
          (stat_stall_q != '1)) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`else
  assign stat_issued = '0;
  assign stat_stall  = '0;
`endif

endmodule
